// File: rtl/ym_clk_phase_gen.sv
// ym_clk_phase_gen: two-phase, non-overlapping clock-enable generator.
//
// Derives the c1/c2 phase enables from MCLK and keeps the per-slot index and
// frame sync that downstream datapaths use to address per-slot state.
//
// Parameters:
//   DIV   - MCLK cycles per phase half-period (phase high + gap), >= 2
//   GAP   - MCLK cycles of non-overlap after each phase, 1 <= GAP <= DIV-1
//   SLOTS - slots per frame, >= 2
//
// Ports:
//   MCLK   in   master clock, all state updates on posedge
//   rst    in   synchronous active-high reset
//   c1     out  phase-1 enable (registered)
//   c2     out  phase-2 enable (registered)
//   slot   out  current slot index (registered)
//   sync   out  one-cycle pulse on the first cycle of PH1 in slot 0
//   halt   in   debug freeze request          (YM_CLKGEN_DBG_EN only)
//   step   in   debug single-period advance   (YM_CLKGEN_DBG_EN only)
//   halted out  phases frozen                 (YM_CLKGEN_DBG_EN only)
//
// Build option: define YM_CLKGEN_DBG_EN to add the halt/single-step facility.

module ym_clk_phase_gen #(
  parameter int unsigned DIV   = 6,
  parameter int unsigned GAP   = 1,
  parameter int unsigned SLOTS = 24
) (
  input  logic                     MCLK,
  input  logic                     rst,
  output logic                     c1,
  output logic                     c2,
  output logic [$clog2(SLOTS)-1:0] slot,
  output logic                     sync
`ifdef YM_CLKGEN_DBG_EN
  ,
  input  logic                     halt,
  input  logic                     step,
  output logic                     halted
`endif
);

  localparam int unsigned CntW  = $clog2(DIV);
  localparam int unsigned SlotW = $clog2(SLOTS);

  localparam logic [CntW-1:0]  PhLoad  = CntW'(DIV - GAP - 1);
  localparam logic [CntW-1:0]  GapLoad = CntW'(GAP - 1);
  localparam logic [SlotW-1:0] SlotMax = SlotW'(SLOTS - 1);

`ifdef YM_CLKGEN_DBG_EN
  typedef enum logic [2:0] {StPh1, StGap1, StPh2, StGap2, StHalt} state_e;
`else
  typedef enum logic [1:0] {StPh1, StGap1, StPh2, StGap2} state_e;
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SlotW-1:0] slot_d;
  logic [SlotW-1:0] slot_inc;

  // Exact wrap for non-power-of-two slot counts.
  assign slot_inc = (slot == SlotMax) ? '0 : slot + SlotW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end else begin
      case (state_q)
        StPh1: begin
          state_d = StGap1;
          cnt_d   = GapLoad;
        end
        StGap1: begin
          state_d = StPh2;
          cnt_d   = PhLoad;
        end
        StPh2: begin
          state_d = StGap2;
          cnt_d   = GapLoad;
        end
        StGap2: begin
`ifdef YM_CLKGEN_DBG_EN
          // Only this boundary is safe to freeze at: a full period has completed.
          if (halt) begin
            state_d = StHalt;
            cnt_d   = '0;
          end else
`endif
          begin
            state_d = StPh1;
            cnt_d   = PhLoad;
            slot_d  = slot_inc;
          end
        end
`ifdef YM_CLKGEN_DBG_EN
        StHalt: begin
          // Resume and single-step both start a new period; whether the block
          // re-halts is decided again at the end of GAP2.
          if (!halt || step) begin
            state_d = StPh1;
            cnt_d   = PhLoad;
            slot_d  = slot_inc;
          end
        end
`endif
        default: begin
          state_d = StGap2;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (rst) begin
      state_q <= StGap2;
      cnt_q   <= '0;
      slot    <= SlotMax;
      c1      <= 1'b0;
      c2      <= 1'b0;
      sync    <= 1'b0;
`ifdef YM_CLKGEN_DBG_EN
      halted  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot    <= slot_d;
      // Outputs are decoded from the next state so they are flop outputs.
      c1      <= (state_d == StPh1);
      c2      <= (state_d == StPh2);
      sync    <= (state_d == StPh1) && (state_q != StPh1) && (slot_d == '0);
`ifdef YM_CLKGEN_DBG_EN
      halted  <= (state_d == StHalt);
`endif
    end
  end

endmodule

// File: tb/tb_ym_clk_phase_gen.sv
// Self-checking bench for ym_clk_phase_gen. Two instances (default parameters
// and DIV=2/GAP=1/SLOTS=5) are driven with randomized reset (and debug
// halt/step when YM_CLKGEN_DBG_EN is defined). A position-in-period model
// predicts every cycle's outputs into a queue; a monitor pops and compares.

module tb_ym_clk_phase_gen;

  localparam int DivA = 6, GapA = 1, SlotsA = 24;
  localparam int DivB = 2, GapB = 1, SlotsB = 5;

  logic MCLK = 1'b0;
  logic rst  = 1'b1;
  logic halt = 1'b0;
  logic step = 1'b0;

  logic       a_c1, a_c2, a_sync;
  logic [4:0] a_slot;
  logic       b_c1, b_c2, b_sync;
  logic [2:0] b_slot;
  logic       a_halted, b_halted;

  int checks   = 0;
  int failures = 0;

  always #5 MCLK = ~MCLK;

  ym_clk_phase_gen #(.DIV(DivA), .GAP(GapA), .SLOTS(SlotsA)) dut_a (
    .MCLK   (MCLK),
    .rst    (rst),
    .c1     (a_c1),
    .c2     (a_c2),
    .slot   (a_slot),
    .sync   (a_sync)
`ifdef YM_CLKGEN_DBG_EN
    ,
    .halt   (halt),
    .step   (step),
    .halted (a_halted)
`endif
  );

  ym_clk_phase_gen #(.DIV(DivB), .GAP(GapB), .SLOTS(SlotsB)) dut_b (
    .MCLK   (MCLK),
    .rst    (rst),
    .c1     (b_c1),
    .c2     (b_c2),
    .slot   (b_slot),
    .sync   (b_sync)
`ifdef YM_CLKGEN_DBG_EN
    ,
    .halt   (halt),
    .step   (step),
    .halted (b_halted)
`endif
  );

`ifndef YM_CLKGEN_DBG_EN
  assign a_halted = 1'b0;
  assign b_halted = 1'b0;
`endif

  // Model: position within the 2*DIV period, slot number, frozen flag.
  typedef struct {
    int pos;
    int s;
    bit h;
  } mdl_t;

  typedef struct packed {
    logic        c1;
    logic        c2;
    logic [31:0] slot;
    logic        sync;
    logic        halted;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t q[$];
  mdl_t  ma, mb;

  function automatic mdl_t mstep(mdl_t m, bit r, bit hl, bit st, int div, int slots);
    if (r) begin
      m.pos = 2 * div - 1;
      m.s   = slots - 1;
      m.h   = 1'b0;
    end else if (m.h) begin
      if (!hl || st) begin
        m.h   = 1'b0;
        m.pos = 0;
        m.s   = (m.s + 1) % slots;
      end
    end else if (m.pos == 2 * div - 1) begin
      if (hl) m.h = 1'b1;
      else begin
        m.pos = 0;
        m.s   = (m.s + 1) % slots;
      end
    end else begin
      m.pos = m.pos + 1;
    end
    return m;
  endfunction

  function automatic exp_t mexp(mdl_t m, int div, int gap);
    exp_t e;
    e.c1     = !m.h && (m.pos < div - gap);
    e.c2     = !m.h && (m.pos >= div) && (m.pos < 2 * div - gap);
    e.slot   = 32'(m.s);
    e.sync   = !m.h && (m.pos == 0) && (m.s == 0);
    e.halted = m.h;
    return e;
  endfunction

  // One MCLK cycle of stimulus; expectation is for the flops after the next edge.
  task automatic cyc(input bit r, input bit hl, input bit st);
    pair_t p;
    @(negedge MCLK);
    rst  = r;
    halt = hl;
    step = st;
`ifndef YM_CLKGEN_DBG_EN
    hl = 1'b0;
    st = 1'b0;
`endif
    ma  = mstep(ma, r, hl, st, DivA, SlotsA);
    mb  = mstep(mb, r, hl, st, DivB, SlotsB);
    p.a = mexp(ma, DivA, GapA);
    p.b = mexp(mb, DivB, GapB);
    q.push_back(p);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare just after each edge.
  initial begin
    pair_t e;
    forever begin
      @(posedge MCLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("a_c1",      32'(a_c1),     32'(e.a.c1));
        chk("a_c2",      32'(a_c2),     32'(e.a.c2));
        chk("a_slot",    32'(a_slot),   e.a.slot);
        chk("a_sync",    32'(a_sync),   32'(e.a.sync));
        chk("a_overlap", 32'(a_c1 & a_c2), 32'd0);
        chk("b_c1",      32'(b_c1),     32'(e.b.c1));
        chk("b_c2",      32'(b_c2),     32'(e.b.c2));
        chk("b_slot",    32'(b_slot),   e.b.slot);
        chk("b_sync",    32'(b_sync),   32'(e.b.sync));
`ifdef YM_CLKGEN_DBG_EN
        chk("a_halted",  32'(a_halted), 32'(e.a.halted));
        chk("b_halted",  32'(b_halted), 32'(e.b.halted));
`endif
      end
    end
  end

  initial begin
    int rst_left;
    int n;
    bit hv;
    ma = '{pos: 0, s: 0, h: 1'b0};
    mb = '{pos: 0, s: 0, h: 1'b0};

    // Reset release with defaults.
    repeat (3) cyc(1'b1, 1'b0, 1'b0);

    // Free-running with occasional random resets.
    rst_left = 0;
    for (int i = 0; i < 10000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 1999) == 0) rst_left = $urandom_range(1, 3);
      cyc(rst_left != 0, 1'b0, 1'b0);
      if (rst_left != 0) rst_left--;
    end

    // Reset asserted in the 3rd cycle of PH2 of slot 7.
    n = 0;
    while (!(ma.s == 7 && ma.pos == DivA + 2) && n < 400) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_slot7_ph2", 32'(n < 400), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (30) cyc(1'b0, 1'b0, 1'b0);

`ifdef YM_CLKGEN_DBG_EN
    // Halt raised during PH1 of slot 2, held; then one step; then resume.
    n = 0;
    while (!(ma.s == 2 && ma.pos == 1) && n < 400) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_slot2_ph1", 32'(n < 400), 32'd1);
    repeat (80) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (40) cyc(1'b0, 1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);

    // Random halt/step/reset mix.
    hv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) hv = ~hv;
      cyc($urandom_range(0, 499) == 0, hv, $urandom_range(0, 19) == 0);
    end
`else
    hv = 1'b0;
    n  = 0;
`endif

    repeat (2) @(posedge MCLK);
    #2;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ym_clk_phase_gen.md
# ym_clk_phase_gen

Two-phase, non-overlapping clock-enable generator that sits directly upstream of every common storage cell. It derives the `c1`/`c2` phase enables from MCLK, which drive all shift registers, latches and counters in the design. It also maintains the slot counter and frame sync that the YM3438/YM7101 datapaths index their per-slot state by. An optional debug halt/single-step facility can freeze the phases at a safe boundary.

## Interface
Parameters:
- `DIV`, default 6: MCLK cycles per phase half-period, phase-high plus gap. Must be ≥2.
- `GAP`, default 1: MCLK cycles of non-overlap after each phase. Must satisfy 1 ≤ GAP ≤ DIV-1.
- `SLOTS`, default 24: slots per frame. Must be ≥2.

Ports:
- `MCLK`  in  1  master clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `c1`  out  1  phase-1 enable, registered.
- `c2`  out  1  phase-2 enable, registered.
- `slot`  out  $clog2(SLOTS)  current slot index, registered.
- `sync`  out  1  one-MCLK pulse at the start of slot 0.
- `halt`  in  1  debug freeze request. Present only with `YM_CLKGEN_DBG_EN`.
- `step`  in  1  debug single-period advance. Present only with `YM_CLKGEN_DBG_EN`.
- `halted`  out  1  phases frozen. Present only with `YM_CLKGEN_DBG_EN`.

## Operation
- FSM states: PH1 → GAP1 → PH2 → GAP2 → PH1, plus HALT (debug builds only).
- Down-counter `cnt`: loads DIV-GAP-1 on entry to PH1/PH2 and GAP-1 on entry to GAP1/GAP2. The state advances when `cnt`==0.
- Outputs: `c1`=1 only in PH1; `c2`=1 only in PH2; both are 0 in GAP1, GAP2 and HALT. `c1 & c2` is never 1.
- Slot counter: increments on each GAP2→PH1 transition and wraps SLOTS-1 → 0.
- `sync`: equals 1 for exactly the first MCLK cycle of PH1 when `slot`==0.
- Reset (`rst`=1 at a posedge):
  - state = GAP2 with `cnt`=0, `slot`=SLOTS-1;
  - `c1`=`c2`=`sync`=0, `halted`=0.
  - `rst` overrides `halt`/`step` and takes effect mid-phase without completing the period.
- Widths: `cnt` is $clog2(DIV) bits. `slot` compare and wrap are exact for non-power-of-2 SLOTS.

## Timing
- Period is 2·DIV MCLK cycles: `c1` high DIV-GAP cycles, low GAP cycles; then `c2` high DIV-GAP cycles, low GAP cycles.
- Defaults: `c1` high 5, gap 1, `c2` high 5, gap 1. Period 12 MCLK; frame 288 MCLK.
- First posedge with `rst`=0: enters PH1, so `c1`=1, `slot`=0, `sync`=1 in that cycle. `c2` first rises DIV cycles later.
- Every output is a flop output; there is no combinational path from inputs to outputs.
- Debug:
  - `halt` is sampled only in the last cycle of GAP2. If it is 1, the next state is HALT instead of PH1, `slot` does not increment, and `halted`=1 from the next cycle.
  - `halt` asserted mid-period lets the current period complete first.
  - In HALT, `step`=1 for one cycle enters PH1 on the next edge and increments `slot`. The block runs exactly one full period, then returns to HALT, provided `halt` is still 1.
  - In HALT, `halt`=0 enters PH1 on the next edge and resumes free-running. `step` is ignored outside HALT.
  - If `halt`=0 and `step`=1 together in HALT, treat as resume.

## Configuration
- `YM_CLKGEN_DBG_EN` defined:
  - `halt`, `step` and `halted` ports and the HALT state exist, as described above.
- `YM_CLKGEN_DBG_EN` undefined:
  - those ports and the HALT state are absent;
  - the block is free-running after reset and GAP2 always proceeds to PH1.

## Test plan
- Reset release, defaults: hold `rst` 3 cycles, then release → cycle 0: `c1`=1, `slot`=0, `sync`=1; cycles 0–4 `c1`=1; cycle 5 both 0; cycles 6–10 `c2`=1; cycle 11 both 0; cycle 12 `c1`=1, `slot`=1, `sync`=0.
- Non-overlap and duty, free-running 10 000 cycles: `c1 & c2` is never 1, and every `c1`/`c2` pulse is exactly 5 cycles wide.
- Slot wrap:
  - defaults: after 23 periods `slot`=23; next PH1 entry gives `slot`=0 with a single-cycle `sync`; exactly one `sync` per 288 cycles.
  - SLOTS=5: `slot` sequence is 0,1,2,3,4,0.
- Minimum parameters DIV=2, GAP=1: pattern `c1`,0,`c2`,0 repeating with period 4 cycles, each phase 1 cycle wide.
- Reset mid-operation: assert `rst` in the 3rd cycle of PH2 of slot 7 → next cycle `c2`=0, `slot`=23; after release the first-cycle behaviour is identical to scenario 1.
- Debug (`YM_CLKGEN_DBG_EN`):
  - raise `halt` during PH1 of slot 2 → the period completes, `halted`=1, `slot` stays 2, and `c1`=`c2`=0 for 50 cycles;
  - pulse `step` → one 12-cycle period runs with `slot`=3, then the block re-halts;
  - drop `halt` → the next cycle has `c1`=1 and `slot`=4.
